// File: rtl/seven_seg_scan_n_if.sv
// Bundle of display-side signals between the value logic and the seven-segment scanner.
interface seven_seg_scan_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              bright;
  logic [6:0]              segments;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   anodes;
  logic                    frame_start;

  modport master (
    output en, digits, dp_in, blank, bright,
    input  segments, dp, anodes, frame_start
  );

  modport slave (
    input  en, digits, dp_in, blank, bright,
    output segments, dp, anodes, frame_start
  );
endinterface

// File: rtl/seven_seg_scan_n.sv
// Multiplexed hex seven-segment scanner with PWM brightness and per-frame shadow latching.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan_n #(
  parameter int NUM_DIGITS = 4,
  parameter int PHASE_LEN  = 15625
) (
  input  logic             clk,
  input  logic             reset_n,
  seven_seg_scan_n_if.slave bus
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PCNT_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PHASE_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PCNT_W-1:0]       pcnt;
  logic [3:0]              phase;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   anodes_q;
  logic                    fs_q;

  logic                    at_start;
  logic [4*NUM_DIGITS-1:0] eff_digits;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_dark;
  logic                    lit;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   anodes_next;

  function automatic logic [6:0] glyph(input logic [3:0] value);
    case (value)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // On the shadow-load cycle the live inputs are shown directly, so the whole frame matches one sample.
  always_comb begin
    at_start   = (idx == '0) && (phase == 4'd0) && (pcnt == '0);
    eff_digits = at_start ? bus.digits : shadow_digits;
    eff_dp     = at_start ? bus.dp_in  : shadow_dp;
    eff_blank  = at_start ? bus.blank  : shadow_blank;
  end

`ifdef SEVEN_SEG_LZB_EN
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (!seen && (eff_digits[4*i +: 4] == 4'h0) && !eff_dp[i]) begin
        lz_mask[i] = 1'b1;
      end else begin
        seen = 1'b1;
      end
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    cur_digit   = 4'h0;
    cur_dp      = 1'b0;
    cur_dark    = 1'b1;
    anodes_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = eff_digits[4*i +: 4];
        cur_dp    = eff_dp[i];
        cur_dark  = eff_blank[i] | lz_mask[i];
      end
    end
    lit      = bus.en && (phase < bus.bright) && !cur_dark;
    seg_next = lit ? glyph(cur_digit) : 7'h7F;
    dp_next  = !(lit && cur_dp);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anodes_next[i] = !(lit && (idx == IDX_W'(i)));
    end
  end

  // Nested prescaler / phase / digit counters plus the frame shadow registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt          <= '0;
      phase         <= 4'd0;
      idx           <= '0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '0;
    end else if (bus.en) begin
      if (at_start) begin
        shadow_digits <= bus.digits;
        shadow_dp     <= bus.dp_in;
        shadow_blank  <= bus.blank;
      end
      if (pcnt == PCNT_LAST) begin
        pcnt <= '0;
        if (phase == 4'd15) begin
          phase <= 4'd0;
          idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          phase <= phase + 4'd1;
        end
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      anodes_q <= '1;
      fs_q     <= 1'b0;
    end else begin
      seg_q    <= seg_next;
      dp_q     <= dp_next;
      anodes_q <= anodes_next;
      fs_q     <= bus.en && at_start;
    end
  end

  assign bus.segments    = seg_q;
  assign bus.dp          = dp_q;
  assign bus.anodes      = anodes_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Directed bench for seven_seg_scan_n: 4 digits, 2-cycle phases (32-cycle slots, 128-cycle frames).
module tb_seven_seg_scan_n;

  localparam int ND = 4;
  localparam int PL = 2;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp_in;
    logic [3:0]      blank;
    logic [3:0]      bright;
    logic [3:0]      lz_mask;
    logic [3:0][6:0] glyph;
    string           name;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [11];

  seven_seg_scan_n_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_n #(.NUM_DIGITS(ND), .PHASE_LEN(PL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                                input logic [3:0] br);
    @(negedge clk);
    reset_n    = 1'b0;
    bus.en     = 1'b0;
    bus.digits = d;
    bus.dp_in  = p;
    bus.blank  = b;
    bus.bright = br;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus.en  = 1'b1;
  endtask

  task automatic check_output(input string name, input logic [3:0] an, input logic [6:0] seg,
                              input logic dpv, input logic fs);
    checks++;
    if ({bus.anodes, bus.segments, bus.dp, bus.frame_start} !== {an, seg, dpv, fs}) begin
      errors++;
      $display("[TB] FAIL %s: got anodes=%b seg=%b dp=%b fs=%b, want anodes=%b seg=%b dp=%b fs=%b",
               name, bus.anodes, bus.segments, bus.dp, bus.frame_start, an, seg, dpv, fs);
    end
  endtask

  // Watches one full frame, sample k reflecting counter state k of the frame.
  task automatic check_frame(input logic [3:0][6:0] g, input logic [3:0] eb, input logic [3:0] dpv,
                             input logic [3:0] br, input int change_at, input logic [15:0] new_digits,
                             input string name);
    int err_an = 0, err_seg = 0, err_dp = 0, err_fs = 0;
    int k_an = 0, k_seg = 0, k_dp = 0, k_fs = 0;
    logic [3:0] a_an = 0, x_an = 0;
    logic [6:0] a_seg = 0, x_seg = 0;
    logic a_dp = 0, x_dp = 0, a_fs = 0, x_fs = 0;
    for (int k = 0; k < ND * 16 * PL; k++) begin
      int slot, ph;
      logic lit;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp, e_fs;
      @(negedge clk);
      slot  = k / (16 * PL);
      ph    = (k % (16 * PL)) / PL;
      lit   = (ph < int'(br)) && !eb[slot];
      e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
      e_seg = lit ? g[slot] : 7'h7F;
      e_dp  = !(lit && dpv[slot]);
      e_fs  = (k == 0);
      if (bus.anodes !== e_an) begin
        if (err_an == 0) begin k_an = k; a_an = bus.anodes; x_an = e_an; end
        err_an++;
      end
      if (bus.segments !== e_seg) begin
        if (err_seg == 0) begin k_seg = k; a_seg = bus.segments; x_seg = e_seg; end
        err_seg++;
      end
      if (bus.dp !== e_dp) begin
        if (err_dp == 0) begin k_dp = k; a_dp = bus.dp; x_dp = e_dp; end
        err_dp++;
      end
      if (bus.frame_start !== e_fs) begin
        if (err_fs == 0) begin k_fs = k; a_fs = bus.frame_start; x_fs = e_fs; end
        err_fs++;
      end
      if (k == change_at) bus.digits = new_digits;
    end
    checks += 4;
    if (err_an != 0) begin
      errors++;
      $display("[TB] FAIL %s anodes: %0d bad cycles, first at %0d got %b want %b", name, err_an, k_an, a_an, x_an);
    end
    if (err_seg != 0) begin
      errors++;
      $display("[TB] FAIL %s segments: %0d bad cycles, first at %0d got %b want %b", name, err_seg, k_seg, a_seg, x_seg);
    end
    if (err_dp != 0) begin
      errors++;
      $display("[TB] FAIL %s dp: %0d bad cycles, first at %0d got %b want %b", name, err_dp, k_dp, a_dp, x_dp);
    end
    if (err_fs != 0) begin
      errors++;
      $display("[TB] FAIL %s frame_start: %0d bad cycles, first at %0d got %b want %b", name, err_fs, k_fs, a_fs, x_fs);
    end
  endtask

  initial begin
    logic [3:0] eb;
    vecs[0]  = '{16'h1234, 4'b0000, 4'b0000, 4'd15, 4'b0000, {G1, G2, G3, G4}, "bright15"};
    vecs[1]  = '{16'h1234, 4'b0000, 4'b0000, 4'd0,  4'b0000, {G1, G2, G3, G4}, "bright0"};
    vecs[2]  = '{16'h1234, 4'b0000, 4'b0000, 4'd8,  4'b0000, {G1, G2, G3, G4}, "bright8"};
    vecs[3]  = '{16'h1234, 4'b0001, 4'b0100, 4'd15, 4'b0000, {G1, G2, G3, G4}, "blank_dp"};
    vecs[4]  = '{16'hABCD, 4'b0000, 4'b0000, 4'd15, 4'b0000, {GA, GB, GC, GD}, "abcd"};
    vecs[5]  = '{16'h5678, 4'b1010, 4'b0000, 4'd1,  4'b0000, {G5, G6, G7, G8}, "dp_bright1"};
    vecs[6]  = '{16'h90EF, 4'b0000, 4'b0000, 4'd4,  4'b0000, {G9, G0, GE, GF}, "90ef"};
    vecs[7]  = '{16'h0050, 4'b0000, 4'b0000, 4'd15, 4'b1100, {G0, G0, G5, G0}, "zeros_0050"};
    vecs[8]  = '{16'h0000, 4'b0000, 4'b0000, 4'd15, 4'b1110, {G0, G0, G0, G0}, "zeros_0000"};
    vecs[9]  = '{16'h0000, 4'b0100, 4'b0000, 4'd12, 4'b1000, {G0, G0, G0, G0}, "zeros_dp2"};
    vecs[10] = '{16'h1234, 4'b0000, 4'b1111, 4'd15, 4'b0000, {G1, G2, G3, G4}, "blank_all"};

    bus.en     = 1'b0;
    bus.digits = '0;
    bus.dp_in  = '0;
    bus.blank  = '0;
    bus.bright = 4'd0;
    repeat (3) @(negedge clk);
    check_output("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);

    for (int i = 0; i < 11; i++) begin
`ifdef SEVEN_SEG_LZB_EN
      eb = vecs[i].blank | vecs[i].lz_mask;
`else
      eb = vecs[i].blank;
`endif
      apply_stimulus(vecs[i].digits, vecs[i].dp_in, vecs[i].blank, vecs[i].bright);
      check_frame(vecs[i].glyph, eb, vecs[i].dp_in, vecs[i].bright, -1, 16'h0, vecs[i].name);
    end

    // Digits change mid-frame: the old value must persist until the next frame boundary.
    apply_stimulus(16'h1234, 4'b0000, 4'b0000, 4'd15);
    check_frame({G1, G2, G3, G4}, 4'b0000, 4'b0000, 4'd15, 40, 16'hABCD, "hold_old");
    check_frame({GA, GB, GC, GD}, 4'b0000, 4'b0000, 4'd15, -1, 16'h0, "new_frame");

    // en held low for 10 cycles shifts the schedule by 10, then reset lands mid-frame.
    apply_stimulus(16'h1234, 4'b0000, 4'b0000, 4'd15);
    for (int s = 0; s <= 51; s++) begin
      @(negedge clk);
      if (s == 9) check_output("pre_hold", 4'b1110, G4, 1'b1, 1'b0);
      if (s >= 10 && s <= 19) check_output("hold_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
      if (s == 39) check_output("resume_d0", 4'b1110, G4, 1'b1, 1'b0);
      if (s == 40) check_output("resume_gap", 4'hF, 7'h7F, 1'b1, 1'b0);
      if (s == 42) check_output("resume_d1", 4'b1101, G3, 1'b1, 1'b0);
      if (s == 51) check_output("mid_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
      if (s == 9) bus.en = 1'b0;
      if (s == 19) bus.en = 1'b1;
      if (s == 50) reset_n = 1'b0;
    end
    reset_n = 1'b1;
    check_frame({G1, G2, G3, G4}, 4'b0000, 4'b0000, 4'd15, -1, 16'h0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
